lnrv_icb2apb: RTL and testbench
===============================

# lnrv_icb2apb

ICB-slave to APB-master bridge: accepts one ICB command at a time, runs it as an APB4 SETUP/ACCESS transfer, and returns the captured `prdata`/`pslverr` as a single ICB response. It sits between the core-side ICB fabric and the APB peripheral cluster. It is the complement of the APB-to-ICB path.

An optional access timeout terminates hung peripherals with an error response.

## Interface

Parameters:

- `P_ADDR_WIDTH`, 32: address width, ICB and APB.
- `P_DATA_WIDTH`, 32: data width; must be a multiple of 8.
- `P_TIMEOUT`, 256: maximum ACCESS cycles before forced error; 0 disables the timeout.

Ports:

- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `icb_cmd_vld` in 1: command valid.
- `icb_cmd_rdy` out 1: command ready.
- `icb_cmd_write` in 1: 1 = write.
- `icb_cmd_addr` in P_ADDR_WIDTH: byte address.
- `icb_cmd_wdata` in P_DATA_WIDTH: write data.
- `icb_cmd_wstrb` in P_DATA_WIDTH/8: byte strobes.
- `icb_rsp_vld` out 1: response valid.
- `icb_rsp_rdy` in 1: response ready.
- `icb_rsp_err` out 1: pslverr or timeout.
- `icb_rsp_rdata` out P_DATA_WIDTH: read data; 0 for writes and timeouts.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB direction.
- `paddr` out P_ADDR_WIDTH: APB address.
- `pwdata` out P_DATA_WIDTH: APB write data.
- `pstrb` out P_DATA_WIDTH/8: APB strobes; 0 on reads.
- `prdata` in P_DATA_WIDTH: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.

## Operation

- FSM states: IDLE, SETUP, ACCESS, RSP. Reset state is IDLE.
- **IDLE**
  - `icb_cmd_rdy`=1; all other state-driven outputs are 0.
  - On `icb_cmd_vld`&`icb_cmd_rdy`, register addr, write, wdata and wstrb.
  - On a read, register `pwdata`=0 and `pstrb`=0.
  - Transition to SETUP.
- **SETUP**
  - `psel`=1, `penable`=0; `paddr`/`pwrite`/`pwdata`/`pstrb` come from registers.
  - Lasts exactly 1 cycle, then ACCESS. The timeout counter clears to 0.
- **ACCESS**
  - `psel`=1, `penable`=1; APB signals are held stable.
  - `pready`=1:
    - capture `icb_rsp_err`=`pslverr`;
    - capture `icb_rsp_rdata`=`prdata` on a read, 0 on a write;
    - go to RSP.
  - `pready`=0 with P_TIMEOUT≠0 and counter==P_TIMEOUT-1: capture err=1, rdata=0, go to RSP. The APB transfer is abandoned.
  - `pready`=0 otherwise: counter increments and the FSM stays in ACCESS.
  - Counter width is $clog2(P_TIMEOUT)+1. It never wraps, because the transfer terminates first.
- **RSP**
  - `psel`=`penable`=0; `icb_rsp_vld`=1, holding the captured data and err stable.
  - `icb_rsp_rdy`=1 completes the handshake; go to IDLE.
  - `icb_rsp_rdy` low: hold indefinitely.
- `pslverr` is sampled only when `pready`=1 in ACCESS; it is ignored elsewhere.
- `icb_cmd_rdy`=0 in SETUP, ACCESS and RSP. Only one outstanding transaction is allowed.
- Reset mid-operation: the FSM returns to IDLE immediately and asynchronously. `psel`/`penable`/`icb_rsp_vld` drop, and the in-flight command and response are discarded.

## Timing

- Reset values:
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `icb_rsp_vld`, `icb_rsp_err`, `icb_rsp_rdata` are all 0.
  - `icb_cmd_rdy`=1 (IDLE).
- All outputs are registered or decoded from FSM state only. There is no combinational path from any input to any output.
- The command handshake at edge N places SETUP in cycle N+1 and ACCESS in cycle N+2.
- With `pready`=1 in the first ACCESS cycle, `icb_rsp_vld` rises in cycle N+3.
- With `icb_rsp_rdy`=1 at that point, the FSM is in IDLE at N+4 and the next command is accepted at N+4. Throughput is 1 transfer per 4 cycles.
- Each wait state adds 1 cycle.
- A timeout with P_TIMEOUT=T gives exactly T ACCESS cycles; `icb_rsp_vld` rises at N+2+T.

## Test plan

- **Write, no wait.** Cmd write addr=0x1000_0010, wdata=0xDEAD_BEEF, wstrb=0xF.
  - Required: SETUP at N+1 with `psel`=1, `penable`=0, `pwrite`=1, `paddr`/`pwdata`/`pstrb` matching.
  - Required: `penable`=1 at N+2; response err=0, rdata=0 at N+3.
- **Read with 3 wait states.** Cmd read addr=0x1000_0004; `pready` low for 3 ACCESS cycles, then high with prdata=0x1234_5678.
  - Required: rsp rdata=0x1234_5678, err=0, `icb_rsp_vld` at N+6.
  - Required: `pstrb`=0 and `pwdata`=0 throughout.
- **Slave error.** Write with `pready`=1 and `pslverr`=1 → rsp err=1.
- **Timeout.** P_TIMEOUT=4, `pready` held 0.
  - Required: exactly 4 ACCESS cycles, then `psel`=0 and rsp err=1, rdata=0.
  - Required: a later `pready` pulse is ignored.
- **Backpressure.** `icb_rsp_rdy`=0 for 5 cycles with a new `icb_cmd_vld` asserted.
  - Required: rsp stays stable and `icb_cmd_rdy`=0.
  - Required: after rsp_rdy, the new cmd is accepted the next cycle, back-to-back.
- **Reset mid-ACCESS.** Assert `reset_n`=0 in an ACCESS cycle.
  - Required: all outputs reach reset values asynchronously.
  - Required: after release, a new read completes normally.

Source files
------------

// File: rtl/lnrv_icb2apb.sv
// ICB-slave to APB4-master bridge: one outstanding command, run as SETUP/ACCESS,
// answered with a single ICB response; optional ACCESS-phase timeout.
module lnrv_icb2apb #(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_TIMEOUT    = 256
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      icb_cmd_vld,
    output logic                      icb_cmd_rdy,
    input  logic                      icb_cmd_write,
    input  logic [P_ADDR_WIDTH-1:0]   icb_cmd_addr,
    input  logic [P_DATA_WIDTH-1:0]   icb_cmd_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] icb_cmd_wstrb,
    output logic                      icb_rsp_vld,
    input  logic                      icb_rsp_rdy,
    output logic                      icb_rsp_err,
    output logic [P_DATA_WIDTH-1:0]   icb_rsp_rdata,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [P_ADDR_WIDTH-1:0]   paddr,
    output logic [P_DATA_WIDTH-1:0]   pwdata,
    output logic [P_DATA_WIDTH/8-1:0] pstrb,
    input  logic [P_DATA_WIDTH-1:0]   prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    // state    | meaning
    // S_IDLE   | ready for a command, APB bus idle
    // S_SETUP  | APB SETUP phase (psel=1, penable=0), one cycle
    // S_ACCESS | APB ACCESS phase, waiting for pready or timeout
    // S_RSP    | ICB response valid, waiting for icb_rsp_rdy
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RSP    = 2'd3
    } state_t;

    localparam int LP_CNT_W = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT) + 1 : 1;
    localparam logic [LP_CNT_W-1:0] LP_CNT_LAST =
        (P_TIMEOUT > 0) ? LP_CNT_W'(P_TIMEOUT - 1) : '0;

    state_t                    r_state;
    logic [LP_CNT_W-1:0]       r_cnt;
    logic                      r_pwrite;
    logic [P_ADDR_WIDTH-1:0]   r_paddr;
    logic [P_DATA_WIDTH-1:0]   r_pwdata;
    logic [P_DATA_WIDTH/8-1:0] r_pstrb;
    logic                      r_rsp_err;
    logic [P_DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                      w_timeout_hit;

    assign w_timeout_hit = (P_TIMEOUT != 0) && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (icb_cmd_vld) begin
                        r_paddr  <= icb_cmd_addr;
                        r_pwrite <= icb_cmd_write;
                        r_pwdata <= icb_cmd_write ? icb_cmd_wdata : '0;
                        r_pstrb  <= icb_cmd_write ? icb_cmd_wstrb : '0;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt   <= '0;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        r_rsp_err   <= pslverr;
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_state     <= S_RSP;
                    end else if (w_timeout_hit) begin
                        // hung peripheral: abandon the APB transfer
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= S_RSP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RSP: begin
                    if (icb_rsp_rdy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign icb_cmd_rdy   = (r_state == S_IDLE);
    assign psel          = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign penable       = (r_state == S_ACCESS);
    assign icb_rsp_vld   = (r_state == S_RSP);
    assign icb_rsp_err   = r_rsp_err;
    assign icb_rsp_rdata = r_rsp_rdata;
    assign pwrite        = r_pwrite;
    assign paddr         = r_paddr;
    assign pwdata        = r_pwdata;
    assign pstrb         = r_pstrb;

endmodule

// File: tb/tb_lnrv_icb2apb.sv
// Randomized bench for lnrv_icb2apb: each transaction is planned as a timeline
// (cmd, setup, access x a, rsp x d+1) and outputs are checked every cycle.
module tb_lnrv_icb2apb;

    localparam int T = 4;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        icb_cmd_vld = 1'b0;
    logic        icb_cmd_rdy;
    logic        icb_cmd_write = 1'b0;
    logic [31:0] icb_cmd_addr = '0;
    logic [31:0] icb_cmd_wdata = '0;
    logic [3:0]  icb_cmd_wstrb = '0;
    logic        icb_rsp_vld;
    logic        icb_rsp_rdy = 1'b0;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    lnrv_icb2apb #(.P_ADDR_WIDTH(32), .P_DATA_WIDTH(32), .P_TIMEOUT(T)) dut (
        .clk(clk), .reset_n(reset_n),
        .icb_cmd_vld(icb_cmd_vld), .icb_cmd_rdy(icb_cmd_rdy),
        .icb_cmd_write(icb_cmd_write), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wstrb(icb_cmd_wstrb),
        .icb_rsp_vld(icb_rsp_vld), .icb_rsp_rdy(icb_rsp_rdy),
        .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expectations for the current cycle, set by the driver
    logic        chk_en = 1'b0;
    logic        e_cmd_rdy, e_psel, e_pen, e_rsp_vld, e_err;
    logic [31:0] e_rdata;
    cmd_t        e_cmd;

    // DUT response sampled on the rising edge of icb_rsp_vld
    logic        prev_vld = 1'b0;
    int          rise_cyc = 0;
    int          cmd_cyc = 0;
    logic        cap_err;
    logic [31:0] cap_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_rdy", icb_cmd_rdy, e_cmd_rdy);
            chk("psel", psel, e_psel);
            chk("penable", penable, e_pen);
            chk("rsp_vld", icb_rsp_vld, e_rsp_vld);
            if (e_psel) begin
                chk("pwrite", pwrite, e_cmd.wr);
                chk("paddr", paddr, e_cmd.addr);
                chk("pwdata", pwdata, e_cmd.wr ? e_cmd.wdata : 32'h0);
                chk("pstrb", pstrb, e_cmd.wr ? e_cmd.wstrb : 4'h0);
            end
            if (e_rsp_vld) begin
                chk("rsp_err", icb_rsp_err, e_err);
                chk("rsp_rdata", icb_rsp_rdata, e_rdata);
            end
        end
        if (icb_rsp_vld && !prev_vld) begin
            rise_cyc  = cyc;
            cap_err   = icb_rsp_err;
            cap_rdata = icb_rsp_rdata;
        end
        prev_vld = icb_rsp_vld;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic rdy, input logic ps, input logic pe, input logic rv);
        e_cmd_rdy = rdy;
        e_psel    = ps;
        e_pen     = pe;
        e_rsp_vld = rv;
    endtask

    task automatic drive_cmd(input logic vld, input cmd_t c);
        icb_cmd_vld   = vld;
        icb_cmd_write = c.wr;
        icb_cmd_addr  = c.addr;
        icb_cmd_wdata = c.wdata;
        icb_cmd_wstrb = c.wstrb;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.wr    = 1'($urandom);
        c.addr  = $urandom;
        c.wdata = $urandom;
        c.wstrb = 4'($urandom);
        return c;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_psel"}, psel, 1'b0);
        chk({tag, "_penable"}, penable, 1'b0);
        chk({tag, "_pwrite"}, pwrite, 1'b0);
        chk({tag, "_paddr"}, paddr, 32'h0);
        chk({tag, "_pwdata"}, pwdata, 32'h0);
        chk({tag, "_pstrb"}, pstrb, 4'h0);
        chk({tag, "_rsp_vld"}, icb_rsp_vld, 1'b0);
        chk({tag, "_rsp_err"}, icb_rsp_err, 1'b0);
        chk({tag, "_rsp_rdata"}, icb_rsp_rdata, 32'h0);
        chk({tag, "_cmd_rdy"}, icb_cmd_rdy, 1'b1);
    endtask

    task automatic idle_cycles(input int g);
        for (int i = 0; i < g; i++) begin
            drive_cmd(1'b0, rand_cmd());
            pready = 1'($urandom);
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    // w: ACCESS wait states before pready (w >= T means pready never comes)
    // d: cycles icb_rsp_rdy is held low; early: next command presented while busy
    task automatic run_txn(input cmd_t c, input int w, input logic serr, input logic [31:0] rd,
                           input int d, input logic early, input cmd_t nxt);
        int a;
        a = (w < T) ? w + 1 : T;
        drive_cmd(1'b1, c);
        icb_rsp_rdy = 1'($urandom);
        pready      = 1'($urandom);
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        cmd_cyc = cyc;
        tick();
        e_cmd = c;
        drive_cmd(early, early ? nxt : rand_cmd());
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < a; i++) begin
            pready  = (i == w);
            pslverr = (i == w) ? serr : 1'($urandom);
            prdata  = (i == w) ? rd : $urandom;
            set_exp(1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        e_err   = (w >= T) ? 1'b1 : serr;
        e_rdata = (w >= T || c.wr) ? 32'h0 : rd;
        for (int j = 0; j <= d; j++) begin
            icb_rsp_rdy = (j == d);
            pready      = 1'($urandom);
            pslverr     = 1'($urandom);
            prdata      = $urandom;
            set_exp(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        icb_rsp_rdy = 1'b0;
        pready      = 1'b0;
        if (!early) drive_cmd(1'b0, rand_cmd());
    endtask

    initial begin
        cmd_t c, n;
        int   r1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        e_cmd = '0;
        e_err = 1'b0;
        e_rdata = '0;
        #12;
        check_reset_values("por");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        idle_cycles(2);

        // write, no wait states
        c = '{wr: 1'b1, addr: 32'h1000_0010, wdata: 32'hDEAD_BEEF, wstrb: 4'hF};
        run_txn(c, 0, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, c);
        chk("wr_rsp_offset", rise_cyc - cmd_cyc, 3);
        chk("wr_rsp_err", cap_err, 1'b0);
        chk("wr_rsp_rdata", cap_rdata, 32'h0);
        idle_cycles(1);

        // read with 3 wait states
        c = '{wr: 1'b0, addr: 32'h1000_0004, wdata: 32'h5555_AAAA, wstrb: 4'hF};
        run_txn(c, 3, 1'b0, 32'h1234_5678, 0, 1'b0, c);
        chk("rd_rsp_offset", rise_cyc - cmd_cyc, 6);
        chk("rd_rsp_rdata", cap_rdata, 32'h1234_5678);
        chk("rd_rsp_err", cap_err, 1'b0);

        // slave error on a write
        c = '{wr: 1'b1, addr: 32'h2000_0000, wdata: 32'h0000_0001, wstrb: 4'h3};
        run_txn(c, 0, 1'b1, 32'h0, 1, 1'b0, c);
        chk("slverr_rsp_err", cap_err, 1'b1);

        // timeout: pready never comes during ACCESS, later pulses ignored
        c = '{wr: 1'b0, addr: 32'h3000_0008, wdata: 32'h0, wstrb: 4'h0};
        run_txn(c, 20, 1'b0, 32'hCAFE_F00D, 3, 1'b0, c);
        chk("to_rsp_offset", rise_cyc - cmd_cyc, 2 + T);
        chk("to_rsp_err", cap_err, 1'b1);
        chk("to_rsp_rdata", cap_rdata, 32'h0);

        // backpressure with next command waiting, then back-to-back accept
        c = '{wr: 1'b0, addr: 32'h4000_0000, wdata: 32'h0, wstrb: 4'h0};
        n = '{wr: 1'b1, addr: 32'h4000_0004, wdata: 32'h0BAD_F00D, wstrb: 4'hC};
        run_txn(c, 0, 1'b0, 32'h8765_4321, 5, 1'b1, n);
        r1 = rise_cyc;
        run_txn(n, 0, 1'b0, 32'h0, 0, 1'b0, n);
        chk("b2b_rsp_spacing", rise_cyc - r1, 9);

        // reset in the middle of ACCESS
        c = '{wr: 1'b1, addr: 32'h5000_0000, wdata: 32'h1111_2222, wstrb: 4'h1};
        drive_cmd(1'b1, c);
        pready = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        e_cmd = c;
        drive_cmd(1'b0, rand_cmd());
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set_exp(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        #2;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        idle_cycles(1);
        c = '{wr: 1'b0, addr: 32'h5000_0004, wdata: 32'h0, wstrb: 4'h0};
        run_txn(c, 1, 1'b0, 32'hA5A5_5A5A, 0, 1'b0, c);
        chk("post_rst_rdata", cap_rdata, 32'hA5A5_5A5A);
        chk("post_rst_offset", rise_cyc - cmd_cyc, 4);

        // randomized traffic
        c = rand_cmd();
        for (int k = 0; k < 300; k++) begin
            logic early;
            n = rand_cmd();
            early = ($urandom_range(0, 3) == 0);
            run_txn(c, $urandom_range(0, 6), 1'($urandom), $urandom,
                    $urandom_range(0, 3), early, n);
            if (!early) idle_cycles($urandom_range(0, 2));
            c = n;
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
